// File: rtl/alu_seq.sv
// alu_seq: sequencing stage in front of the combinational Alu.
//
// Accepts one operation per IN_VALID/IN_READY handshake, latches the operands
// and drives the Alu from those registers. Ordinary instructions take one
// Alu cycle (EXEC). Instruction 6 (division iteration) runs the Alu for
// DIV_ITERS cycles, feeding Z back into B and DO back into DI, with
// ALU_FIRST raised on the first iteration only. The final Alu result is held
// in an output register until OUT_READY consumes it.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   IN_VALID/IN_READY        request handshake
//   IN_A, IN_B, IN_DI        operands (IN_DI used by instruction 6 only)
//   IN_INST, IN_CI           instruction code, carry in
//   ALU_A/B/DI/INST/CI/FIRST drive to the Alu
//   ALU_Z, ALU_DO, ALU_FLAGS results from the Alu
//   OUT_VALID/OUT_READY      result handshake
//   OUT_Z, OUT_DO, OUT_FLAGS registered result
module alu_seq #(
    parameter int WIDTH     = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    input  logic [WIDTH-1:0] IN_DI,
    input  logic [3:0]       IN_INST,
    input  logic             IN_CI,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [WIDTH-1:0] ALU_DI,
    output logic [3:0]       ALU_INST,
    output logic             ALU_CI,
    output logic             ALU_FIRST,
    input  logic [WIDTH-1:0] ALU_Z,
    input  logic [WIDTH-1:0] ALU_DO,
    input  logic [3:0]       ALU_FLAGS,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_Z,
    output logic [WIDTH-1:0] OUT_DO,
    output logic [3:0]       OUT_FLAGS
);

    localparam int          CW       = $clog2(DIV_ITERS) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITERS - 1);
    localparam logic [3:0]  INST_DIV = 4'd6;

    typedef enum logic [1:0] {IDLE, EXEC, DIV} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opA_q, opB_q, opDI_q;
    logic [3:0]       opI_q;
    logic             opC_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_z_q, out_do_q;
    logic [3:0]       out_flags_q;

    logic accept, capture;

    assign IN_READY = !RST && (state_q == IDLE) && (!out_valid_q || OUT_READY);
    assign accept   = IN_VALID && IN_READY;
    // The Alu result is final at the end of EXEC or of the last DIV iteration.
    assign capture  = (state_q == EXEC) || (state_q == DIV && cnt_q == CNT_LAST);
    assign cnt_d    = cnt_q + CW'(1);

    assign ALU_A     = opA_q;
    assign ALU_B     = opB_q;
    assign ALU_INST  = opI_q;
    assign ALU_CI    = opC_q;
    assign ALU_DI    = (state_q == DIV) ? opDI_q : '0;
    assign ALU_FIRST = (state_q == DIV) && (cnt_q == '0);

    assign OUT_VALID = out_valid_q;
    assign OUT_Z     = out_z_q;
    assign OUT_DO    = out_do_q;
    assign OUT_FLAGS = out_flags_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opA_q       <= '0;
            opB_q       <= '0;
            opDI_q      <= '0;
            opI_q       <= '0;
            opC_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_do_q    <= '0;
            out_flags_q <= '0;
        end else begin
            // A fresh capture wins over consumption of the old result.
            if (capture) begin
                out_z_q     <= ALU_Z;
                out_do_q    <= ALU_DO;
                out_flags_q <= ALU_FLAGS;
                out_valid_q <= 1'b1;
            end else if (OUT_READY) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        opA_q   <= IN_A;
                        opB_q   <= IN_B;
                        opDI_q  <= IN_DI;
                        opI_q   <= IN_INST;
                        opC_q   <= IN_CI;
                        cnt_q   <= '0;
                        state_q <= (IN_INST == INST_DIV) ? DIV : EXEC;
                    end
                end
                EXEC: state_q <= IDLE;
                DIV: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        // Loop the iteration result back; A, INST, CI stay put.
                        opB_q  <= ALU_Z;
                        opDI_q <= ALU_DO;
                        cnt_q  <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: contains a stand-in Alu, a transaction-level model of
// the stage (timer + predicted result) and a per-cycle compare process.
module tb_alu_seq;

    localparam int W = 32;
    localparam int N = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [W-1:0]  IN_A = '0, IN_B = '0, IN_DI = '0;
    logic [3:0]    IN_INST = '0;
    logic          IN_CI = 1'b0;
    logic [W-1:0]  ALU_A, ALU_B, ALU_DI;
    logic [3:0]    ALU_INST;
    logic          ALU_CI, ALU_FIRST;
    logic [W-1:0]  ALU_Z, ALU_DO;
    logic [3:0]    ALU_FLAGS;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b1;
    logic [W-1:0]  OUT_Z, OUT_DO;
    logic [3:0]    OUT_FLAGS;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W), .DIV_ITERS(N)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_A(IN_A), .IN_B(IN_B), .IN_DI(IN_DI), .IN_INST(IN_INST), .IN_CI(IN_CI),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_DI(ALU_DI), .ALU_INST(ALU_INST),
        .ALU_CI(ALU_CI), .ALU_FIRST(ALU_FIRST),
        .ALU_Z(ALU_Z), .ALU_DO(ALU_DO), .ALU_FLAGS(ALU_FLAGS),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_Z(OUT_Z), .OUT_DO(OUT_DO), .OUT_FLAGS(OUT_FLAGS)
    );

    always #5 CLK = ~CLK;

    // Stand-in Alu. Returns {flags, do, z}.
    function automatic logic [67:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] di, input logic [3:0] inst,
                                          input logic ci, input logic first);
        logic [32:0] s;
        logic [31:0] z, dox;
        logic        c, ovf;
        s = '0; z = a ^ b; dox = ~a; c = 1'b0; ovf = 1'b0;
        case (inst)
            4'd2: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
                z = s[31:0]; c = s[32];
                ovf = (a[31] == b[31]) && (z[31] != a[31]);
            end
            4'd3: begin
                s = {1'b0, a} - {1'b0, b};
                z = s[31:0]; c = s[32];
                ovf = (a[31] != b[31]) && (z[31] != a[31]);
            end
            4'd6: begin
                z = b + a + (first ? 32'd16 : 32'd0);
                dox = di + 32'd1;
            end
            4'd15: z = a + 32'd1;
            default: ;
        endcase
        return {1'b0, (z == 32'd0), c, ovf, dox, z};
    endfunction

    always_comb begin
        {ALU_FLAGS, ALU_DO, ALU_Z} = alu_f(ALU_A, ALU_B, ALU_DI, ALU_INST, ALU_CI, ALU_FIRST);
    end

    // Whole-operation result: one Alu pass, or N chained division iterations.
    function automatic logic [67:0] predict(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] di, input logic [3:0] inst,
                                            input logic ci);
        logic [67:0] r;
        logic [31:0] bb, dd;
        if (inst != 4'd6) return alu_f(a, b, 32'd0, inst, ci, 1'b0);
        bb = b; dd = di; r = '0;
        for (int i = 0; i < N; i++) begin
            r  = alu_f(a, bb, dd, inst, ci, i == 0);
            bb = r[31:0];
            dd = r[63:32];
        end
        return r;
    endfunction

    // Model state: busy = edges left until the result lands.
    logic        m_valid = 1'b0;
    logic [31:0] m_z = '0, m_do = '0;
    logic [3:0]  m_fl = '0;
    int          m_busy = 0;
    logic        m_div = 1'b0;
    logic [31:0] m_a = '0;
    logic [3:0]  m_inst = '0;
    logic        m_ci = 1'b0;
    logic [67:0] m_pend = '0;
    int          acc_cnt = 0;

    always @(posedge CLK or posedge RST) begin
        logic rdy;
        if (RST) begin
            m_valid = 1'b0; m_z = '0; m_do = '0; m_fl = '0; m_busy = 0; m_div = 1'b0;
        end else begin
            rdy = (m_busy == 0) && (!m_valid || OUT_READY);
            if (m_busy == 1) begin
                m_valid = 1'b1;
                {m_fl, m_do, m_z} = m_pend;
            end else if (OUT_READY) begin
                m_valid = 1'b0;
            end
            if (m_busy > 0) m_busy--;
            if (IN_VALID && rdy) begin
                m_pend = predict(IN_A, IN_B, IN_DI, IN_INST, IN_CI);
                m_div  = (IN_INST == 4'd6);
                m_busy = m_div ? N : 1;
                m_a = IN_A; m_inst = IN_INST; m_ci = IN_CI;
                acc_cnt++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    logic [31:0] prev_z = '0, prev_do = '0;
    always @(negedge CLK) begin
        if (RST) begin
            chk("in_ready_rst", {31'd0, IN_READY}, 32'd0);
            chk("out_valid_rst", {31'd0, OUT_VALID}, 32'd0);
        end else begin
            chk("in_ready", {31'd0, IN_READY},
                {31'd0, (m_busy == 0) && (!m_valid || OUT_READY)});
            chk("out_valid", {31'd0, OUT_VALID}, {31'd0, m_valid});
            if (m_valid) begin
                chk("out_z", OUT_Z, m_z);
                chk("out_do", OUT_DO, m_do);
                chk("out_flags", {28'd0, OUT_FLAGS}, {28'd0, m_fl});
            end
            chk("alu_first", {31'd0, ALU_FIRST}, {31'd0, m_div && (m_busy == N)});
            if (m_busy > 0) begin
                chk("alu_inst", {28'd0, ALU_INST}, {28'd0, m_inst});
                chk("alu_a", ALU_A, m_a);
                chk("alu_ci", {31'd0, ALU_CI}, {31'd0, m_ci});
                if (!m_div) chk("alu_di_exec", ALU_DI, 32'd0);
                if (m_div && m_busy < N) begin
                    chk("alu_b_chain", ALU_B, prev_z);
                    chk("alu_di_chain", ALU_DI, prev_do);
                end
            end
        end
        prev_z  = ALU_Z;
        prev_do = ALU_DO;
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] di,
                        input logic [3:0] inst, input logic ci);
        int start;
        bit done;
        start = acc_cnt;
        done = 0;
        IN_A = a; IN_B = b; IN_DI = di; IN_INST = inst; IN_CI = ci; IN_VALID = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge CLK); #1;
            done = (acc_cnt != start);
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        IN_VALID = 1'b0;
    endtask

    // Counts negedges until OUT_VALID is seen (bounded).
    task automatic wait_valid(output int lat);
        bit seen;
        seen = 0; lat = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLK);
            lat++;
            seen = OUT_VALID;
        end
        if (!seen) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0;
        logic [31:0] z0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_alu_a", ALU_A, 32'd0);
        chk("rst_alu_first", {31'd0, ALU_FIRST}, 32'd0);
        chk("rst_out_z", OUT_Z, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", {31'd0, IN_READY}, 32'd1);
        @(posedge CLK); #1;

        // Add
        send(32'd1, 32'd1, 32'd0, 4'd2, 1'b0);
        wait_valid(lat);
        chk("add_lat", lat, 32'd2);
        chk("add_z", OUT_Z, 32'd2);
        chk("add_zf", {31'd0, OUT_FLAGS[2]}, 32'd0);
        @(posedge CLK); #1;

        // Subtract to zero
        send(32'd5, 32'd5, 32'd0, 4'd3, 1'b0);
        wait_valid(lat);
        chk("sub_z", OUT_Z, 32'd0);
        chk("sub_zf", {31'd0, OUT_FLAGS[2]}, 32'd1);
        @(posedge CLK); #1;

        // Follow-on instruction 15
        send(32'd0, 32'd0, 32'd0, 4'd15, 1'b0);
        wait_valid(lat);
        chk("i15_z", OUT_Z, 32'd1);
        @(posedge CLK); #1;

        // Backpressure
        OUT_READY = 1'b0;
        send(32'd10, 32'd20, 32'd0, 4'd2, 1'b0);
        wait_valid(lat);
        @(posedge CLK); #1;
        IN_A = 32'd9; IN_B = 32'd4; IN_INST = 4'd3; IN_CI = 1'b0; IN_VALID = 1'b1;
        z0 = OUT_Z;
        chk("bp_first_z", z0, 32'd30);
        a0 = acc_cnt;
        repeat (5) begin
            @(negedge CLK);
            chk("bp_in_ready", {31'd0, IN_READY}, 32'd0);
            chk("bp_z_stable", OUT_Z, 32'd30);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        chk("bp_accept_edge", acc_cnt, a0 + 1);
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("bp_consumed", {31'd0, OUT_VALID}, 32'd0);
        @(negedge CLK);
        chk("bp_second_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("bp_second_z", OUT_Z, 32'd5);
        @(posedge CLK); #1;

        // Division sequencing
        send(32'd3, 32'd0, 32'd7, 4'd6, 1'b0);
        wait_valid(lat);
        chk("div_lat", lat, N + 1);
        chk("div_z", OUT_Z, 32'h70);
        chk("div_do", OUT_DO, 32'd39);
        chk("div_zf", {31'd0, OUT_FLAGS[2]}, 32'd0);
        @(posedge CLK); #1;

        // Idle hold
        repeat (10) begin
            @(negedge CLK);
            chk("idle_valid", {31'd0, OUT_VALID}, 32'd0);
            chk("idle_first", {31'd0, ALU_FIRST}, 32'd0);
            chk("idle_ready", {31'd0, IN_READY}, 32'd1);
        end
        @(posedge CLK); #1;

        // Reset in the middle of a division at cnt=10
        send(32'd3, 32'd0, 32'd7, 4'd6, 1'b0);
        repeat (10) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("arst_z", OUT_Z, 32'd0);
        chk("arst_flags", {28'd0, OUT_FLAGS}, 32'd0);
        chk("arst_first", {31'd0, ALU_FIRST}, 32'd0);
        chk("arst_ready", {31'd0, IN_READY}, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("arst_ready_rel", {31'd0, IN_READY}, 32'd1);
        repeat (40) begin
            @(negedge CLK);
            chk("arst_no_valid", {31'd0, OUT_VALID}, 32'd0);
        end
        @(posedge CLK); #1;

        // Randomized traffic
        begin
            int last_acc;
            last_acc = acc_cnt;
            for (int c = 0; c < 1500; c++) begin
                @(posedge CLK); #1;
                if (IN_VALID && acc_cnt != last_acc) IN_VALID = 1'b0;
                OUT_READY = ($urandom_range(0, 9) < 7);
                if (!IN_VALID && $urandom_range(0, 9) < 6) begin
                    IN_A  = $urandom;
                    IN_B  = $urandom;
                    IN_DI = $urandom;
                    IN_CI = $urandom_range(0, 1);
                    IN_INST = ($urandom_range(0, 3) == 0) ? 4'd6 : 4'($urandom_range(0, 15));
                    IN_VALID = 1'b1;
                    last_acc = acc_cnt;
                end
            end
            @(posedge CLK); #1;
            IN_VALID = 1'b0;
            OUT_READY = 1'b1;
            repeat (40) @(posedge CLK);
        end

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencing stage directly upstream of the combinational `Alu`. It accepts one operation per valid/ready handshake and latches the operands. It drives the ALU ports and, for single-cycle instructions, registers Z/DO/FLAGS into an output holding register. For instruction 6 (division iteration) it runs the ALU for DIV_ITERS consecutive cycles, looping Z back to B and DO back to DI, and pulses FirstCyc on the first iteration.

## Interface
- WIDTH, 32, datapath width; must equal the `Alu` width.
- DIV_ITERS, 32, number of ALU cycles per instruction-6 operation; must be at least 1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  stage can accept a request.
- IN_A, IN_B  in  WIDTH  operands.
- IN_DI  in  WIDTH  initial DI value; used by instruction 6 only.
- IN_INST  in  4  ALU instruction code.
- IN_CI  in  1  carry in.
- ALU_A, ALU_B, ALU_DI  out  WIDTH  drive `Alu` A, B, DI.
- ALU_INST  out  4  drives `Alu` INST.
- ALU_CI  out  1  drives `Alu` CI.
- ALU_FIRST  out  1  drives `Alu` FirstCyc.
- ALU_Z, ALU_DO  in  WIDTH  from `Alu` Z, DO.
- ALU_FLAGS  in  4  from `Alu` FLAGS: bit 0 OVF, bit 1 carry, bit 2 zero, bit 3 reserved.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- OUT_Z, OUT_DO  out  WIDTH  registered result.
- OUT_FLAGS  out  4  registered flags.

## Operation
- States: IDLE, EXEC, DIV.
- Internal registers: opA, opB, opDI, opI, opC, cnt (log2(DIV_ITERS)+1 bits).
- IN_READY = !RST && state==IDLE && (!OUT_VALID || OUT_READY).
- Accept occurs on a CLK edge where IN_VALID && IN_READY. On accept:
  - latch IN_* into op* registers;
  - if IN_INST==6: go to DIV with cnt=0; otherwise go to EXEC.
- The ALU drive is combinational from registers:
  - ALU_A=opA, ALU_B=opB, ALU_INST=opI, ALU_CI=opC.
  - ALU_DI=opDI in DIV, otherwise 0.
  - ALU_FIRST = (state==DIV && cnt==0).
- In IDLE, ALU_* outputs still reflect the op* registers; ALU results are ignored.
- EXEC, one cycle. At the edge ending it:
  - OUT_Z←ALU_Z, OUT_DO←ALU_DO, OUT_FLAGS←ALU_FLAGS, OUT_VALID←1;
  - go to IDLE.
- DIV. At each edge:
  - if cnt==DIV_ITERS-1: capture outputs exactly as in EXEC, OUT_VALID←1, go to IDLE;
  - otherwise: opB←ALU_Z, opDI←ALU_DO, cnt←cnt+1.
- opA, opI and opC are held for the whole DIV sequence.
- OUT_VALID clears at an edge where OUT_READY=1 and no new result is being captured that edge.
- While OUT_VALID=1 and OUT_READY=0:
  - OUT_Z, OUT_DO and OUT_FLAGS are stable;
  - no request is accepted.
- IN_VALID while IN_READY=0 is ignored. The requester holds the request; nothing is queued.
- Every instruction code except 6 (including 14 and 15) takes the EXEC path.
- Arithmetic and flag semantics belong entirely to `Alu`; this block performs no arithmetic except the cnt increment.

## Timing
- Reset (asynchronous on assertion, synchronous release). The following registers take the listed values immediately:
  - state=IDLE, cnt=0, all op* registers 0;
  - OUT_VALID=0, OUT_Z=0, OUT_DO=0, OUT_FLAGS=0;
  - so ALU_A, ALU_B, ALU_DI, ALU_INST, ALU_CI and ALU_FIRST are all 0.
- IN_READY is 0 while RST=1 and becomes 1 in the first cycle after release.
- RST asserted in the middle of EXEC or DIV aborts the operation. No OUT_VALID is produced for it.
- Non-div latency: accept at edge n, then OUT_VALID=1 after edge n+1.
- Div latency: accept at edge n, then OUT_VALID=1 after edge n+DIV_ITERS.
- Back-to-back requests: with OUT_READY held at 1, the next accept can occur at the edge that sets OUT_VALID's successor state (IDLE). Peak throughput is therefore one non-div op every 2 cycles.
- An edge with OUT_READY=1 that is also an accept edge: the old result is consumed and OUT_VALID drops to 0. It rises again when the new op completes.

## Test plan
- Reset test:
  - drive RST high for 3 cycles in the middle of a DIV operation at cnt=10;
  - required: OUT_VALID=0, OUT_Z=0, OUT_FLAGS=0 and ALU_FIRST=0 immediately; IN_READY=0 during reset and 1 the cycle after release; no OUT_VALID for the aborted operation.
- Add: IN_INST=2, A=0x00000001, B=0x00000001, CI=0.
  - Required: OUT_VALID one edge after accept; OUT_Z=0x00000002; OUT_FLAGS[2]=0.
- Subtract to zero: IN_INST=3, A=B=0x00000005.
  - Required: OUT_Z=0, OUT_FLAGS[2]=1.
- Follow-on: IN_INST=15.
  - Required: OUT_Z=0x00000001.
- Backpressure:
  - complete an op with OUT_READY=0 for 5 cycles while IN_VALID=1 with a second op;
  - required: OUT_Z stable and IN_READY=0 throughout; the second op is accepted on the edge where OUT_READY rises; the second result follows one edge later.
- Division sequencing: IN_INST=6, A=0x00000003, B=0, DI=0x00000007, DIV_ITERS=32.
  - ALU_INST=6 for exactly 32 cycles, with ALU_FIRST high only in the first.
  - Each cycle, ALU_B and ALU_DI equal the previous cycle's ALU_Z and ALU_DO; ALU_A=3 throughout.
  - OUT_VALID is set 32 edges after accept; OUT_Z and OUT_DO match the final-cycle ALU_Z and ALU_DO from the bench's `Alu` instance.
- Idle-hold: IN_VALID=0 for 10 cycles after a result is consumed.
  - Required: OUT_VALID=0, state IDLE, no ALU_FIRST pulse.
